dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit sitting between the MEM pipeline stage and the four byte-lane data RAM banks (lane 0–3, 8 bits × 16K each, asynchronous read, synchronous write). It converts a byte-addressed load/store request of size byte, half or word into per-lane addresses, write enables and write bytes. It reassembles and sign/zero-extends load data. It returns one registered response per accepted request over a valid/ready handshake.

## Interface
- ADDR_W, 16, byte address width (64 KiB data space)
- LANE_AW, 14, per-lane word address width; ADDR_W = LANE_AW + 2
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_W  byte address
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned_i  in  1  load zero-extends when high
- req_wdata_i  in  32  store data, low bytes used for byte/half
- rsp_valid_o  out  1  response held
- rsp_ready_i  in  1  consumer takes response
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  request was illegal or misaligned-rejected
- lane_addr_o  out  4*LANE_AW  word address of lane i at bits [i*LANE_AW +: LANE_AW]
- lane_wren_o  out  4  per-lane write enable
- lane_wdata_o  out  32  lane i byte at [8i +: 8]
- lane_rdata_i  in  32  lane i read byte at [8i +: 8], combinational from the RAMs

## Operation
- Accept = req_valid_i & req_ready_o; req_ready_o = !rsp_valid_o | rsp_ready_i (combinational).
- n = 1, 2 or 4 bytes. Byte k (k < n) maps to byte address a+k, which gives lane (a+k)[1:0] and lane word (a+k)>>2 mod 2^LANE_AW.
- Untouched lanes: lane address = a>>2, wren 0, wdata 0.
- Lane outputs are driven combinationally from the request every cycle. lane_wren_o is high only on accept of a legal store.
- Loads: on accept, the byte k of the result is taken from lane (a+k)[1:0]. Bytes n..3 are filled with the sign bit (bit 8n−1) or with 0 when req_unsigned_i is set or n = 4. The result is registered into rsp_rdata_o.
- Stores: on accept, the response registers rdata = 0 and err = 0.
- Errors: size 3, or misalignment (a mod n ≠ 0) when misalignment is disabled. The request is still accepted, with no write. The response has err = 1 and rdata = 0.
- Response register: it is set on accept. It is cleared when rsp_ready_i is high and no new accept occurs. Accept and pop in the same cycle replace the response.

## Timing
- Reset values: rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0; req_ready_o therefore 1.
- Latency: response visible 1 cycle after accept. Throughput is 1 request per cycle while rsp_ready_i is high.
- Store accepted at edge N, load of the same address accepted at edge N+1: the load returns the new data.
- Backpressure: while rsp_valid_o & !rsp_ready_i, the response is held stable, req_ready_o is 0, and all lane_wren_o are 0.
- Reset asserted mid-operation: the pending response is dropped immediately. Stores accepted before the reset edge remain in the RAM.

## Configuration
- DMEM_MISALIGN_EN defined: misaligned half/word accesses complete in one cycle. Each lane uses its own incremented word address. Crossing the top of memory wraps to word 0 with no error.
- DMEM_MISALIGN_EN undefined: any a mod n ≠ 0 gives err = 1 with no write, and the lane addresses all equal a>>2.

## Test plan
- Reset, then SW 0xDEADBEEF @0x0010 -> lane_wren_o 4'b1111, all lane addresses 4. A following LW @0x0010 -> rsp_rdata_o 0xDEADBEEF, err 0, one cycle after accept.
- Byte 0x80 stored at 0x0013. LB @0x0013 -> 0xFFFFFF80. LBU -> 0x00000080. LH @0x0012 with bytes 0x80,0x7F at 0x0012/0x0013 -> 0x00007F80.
- DMEM_MISALIGN_EN: SW 0x11223344 @0x0006 -> lanes 2,3 at word 1 written 0x44,0x33, and lanes 0,1 at word 2 written 0x22,0x11. LW @0x0006 -> 0x11223344.
- DMEM_MISALIGN_EN: SH 0xABCD @0xFFFF -> lane 3 word 16383 = 0xCD and lane 0 word 0 = 0xAB. LHU @0xFFFF -> 0x0000ABCD.
- Without macro: LH @0x0003 -> err 1, rdata 0. SW @0x0002 -> err 1, lane_wren_o 0. Size 3 -> err 1 in both builds.
- Hold rsp_ready_i = 0 after a load -> rsp fields are stable, req_ready_o = 0, and a pending store produces no wren. Then raise rsp_ready_i with back-to-back requests -> one response per cycle.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the MEM stage and four byte-lane data RAM banks.
// Splits byte/half/word requests into per-lane address, write enable and write byte,
// reassembles and extends load data, and returns one registered response per request.
// Optional feature macro: DMEM_MISALIGN_EN (misaligned half/word accesses complete in
// one cycle using per-lane incremented word addresses, wrapping at the top of memory).
module dmem_lsu #(
    parameter int ADDR_W  = 16,
    parameter int LANE_AW = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [4*LANE_AW-1:0] lane_addr_o,
    output logic [3:0]           lane_wren_o,
    output logic [31:0]          lane_wdata_o,
    input  logic [31:0]          lane_rdata_i
);
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               accept;
    logic [1:0]         byte_ofs;
    logic [LANE_AW-1:0] base_word;
    logic [2:0]         num_bytes;
    logic               size_bad;
    logic               req_bad;
    logic [31:0]        raw_data;
    logic [31:0]        load_data;

    assign byte_ofs    = req_addr_i[1:0];
    assign base_word   = req_addr_i[ADDR_W-1:2];
    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    // Decode access size into a byte count; size 3 is illegal.
    always_comb begin
        size_bad  = 1'b0;
        num_bytes = 3'd4;
        case (req_size_i)
            2'd0:    num_bytes = 3'd1;
            2'd1:    num_bytes = 3'd2;
            2'd2:    num_bytes = 3'd4;
            default: size_bad  = 1'b1;
        endcase
    end

`ifdef DMEM_MISALIGN_EN
    assign req_bad = size_bad;
`else
    // Without misaligned support any half/word not on its natural boundary is rejected.
    assign req_bad = size_bad
                   || ((req_size_i == 2'd1) && byte_ofs[0])
                   || ((req_size_i == 2'd2) && (byte_ofs != 2'd0));
`endif

    // Per-lane steering: lane gi carries request byte k = gi - offset (mod 4);
    // result byte gi comes from lane offset + gi (mod 4).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [1:0] k_idx;
            logic       touched;
            logic [1:0] src_lane;

            assign k_idx   = 2'(gi) - byte_ofs;
            assign touched = !size_bad && ({1'b0, k_idx} < num_bytes);

`ifdef DMEM_MISALIGN_EN
            // Lanes below the start offset hold bytes that spilled into the next word.
            assign lane_addr_o[gi*LANE_AW +: LANE_AW] =
                (touched && (2'(gi) < byte_ofs))
                    ? base_word + {{(LANE_AW-1){1'b0}}, 1'b1}
                    : base_word;
`else
            assign lane_addr_o[gi*LANE_AW +: LANE_AW] = base_word;
`endif
            assign lane_wdata_o[8*gi +: 8] = (touched && req_we_i)
                                           ? req_wdata_i[{k_idx, 3'b000} +: 8] : 8'h00;
            assign lane_wren_o[gi]         = accept && req_we_i && !req_bad && touched;

            assign src_lane                = byte_ofs + 2'(gi);
            assign raw_data[8*gi +: 8]     = lane_rdata_i[{src_lane, 3'b000} +: 8];
        end
    endgenerate

    // Sign- or zero-extend the reassembled load bytes to 32 bits.
    always_comb begin
        load_data = raw_data;
        case (req_size_i)
            2'd0:    load_data = {{24{raw_data[7]  & ~req_unsigned_i}}, raw_data[7:0]};
            2'd1:    load_data = {{16{raw_data[15] & ~req_unsigned_i}}, raw_data[15:0]};
            default: load_data = raw_data;
        endcase
    end

    // Response next state: load on accept, clear on pop, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (req_we_i || req_bad) ? 32'h0 : load_data;
            rsp_err_d   = req_bad;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
        end
    end

    // Response register; reset drops any pending response immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: four byte-lane RAMs around the DUT, a flat byte-array
// reference memory, directed scenarios and randomized traffic.
module tb_dmem_lsu;
    localparam int AW  = 16;
    localparam int LAW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [AW-1:0]     req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [4*LAW-1:0]  lane_addr;
    logic [3:0]        lane_wren;
    logic [31:0]       lane_wdata, lane_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Lane RAMs (async read, sync write) and the byte-addressed reference memory.
    logic [7:0] ram [4][16384];
    logic [7:0] ref_mem [65536];
    logic       ram_clear;

    // Captured pre-edge DUT outputs and model expectations for the last transaction.
    logic              cap_ready;
    logic [3:0]        cap_wren;
    logic [4*LAW-1:0]  cap_addr;
    logic [31:0]       cap_wdata;
    logic              exp_err;
    logic [31:0]       exp_rdata;
    logic [3:0]        exp_wren;
    logic [4*LAW-1:0]  exp_addr;
    logic [31:0]       exp_wdata;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(AW), .LANE_AW(LAW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err),
        .lane_addr_o(lane_addr), .lane_wren_o(lane_wren), .lane_wdata_o(lane_wdata),
        .lane_rdata_i(lane_rdata)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ram
            assign lane_rdata[8*gi +: 8] = ram[gi][lane_addr[gi*LAW +: LAW]];
        end
    endgenerate

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 16384; j++)
                    ram[i][j] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (lane_wren[i]) ram[i][lane_addr[i*LAW +: LAW]] <= lane_wdata[8*i +: 8];
        end
    end

    // Drive one request for one cycle; compute expectations from the byte-level model.
    task automatic issue(input logic we, input logic [15:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
        int n;
        logic bad;
        logic [31:0] v;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        #1;
        cap_ready = req_ready; cap_wren = lane_wren;
        cap_addr  = lane_addr; cap_wdata = lane_wdata;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = (sz == 2'd3);
`ifndef DMEM_MISALIGN_EN
        if ((int'(a) % n) != 0) bad = 1'b1;
`endif
        exp_err = bad; exp_rdata = 32'h0; exp_wren = 4'h0; exp_wdata = 32'h0;
        for (int i = 0; i < 4; i++) exp_addr[i*LAW +: LAW] = a[15:2];
        if (!bad) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) begin
                int ba;
                int ln;
                ba = (int'(a) + k) % 65536;
                ln = ba % 4;
`ifdef DMEM_MISALIGN_EN
                exp_addr[ln*LAW +: LAW] = 14'(ba / 4);
`endif
                v[8*k +: 8] = ref_mem[ba];
                if (we) begin
                    exp_wren[ln] = 1'b1;
                    exp_wdata[8*ln +: 8] = wd[8*k +: 8];
                end
            end
            if (!we) begin
                if (n < 4 && !uns && v[8*n-1])
                    for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
                exp_rdata = v;
            end
        end
        @(posedge clk); #1;
        if (cap_ready && we && !bad)
            for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 65536] = wd[8*k +: 8];
        req_valid = 1'b0;
        $display("txn we=%0d addr=%h size=%0d uns=%0d wdata=%h -> valid=%0d rdata=%h err=%0d wren=%b",
                 we, a, sz, uns, wd, rsp_valid, rsp_rdata, rsp_err, cap_wren);
    endtask

    task automatic test_reset();
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else pass_cnt++;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rsp_err); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_word();
        issue(1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF);
        total_cnt++; if (cap_wren !== 4'b1111) $display("FAIL sw_wren: got %b want 1111", cap_wren); else pass_cnt++;
        total_cnt++; if (cap_addr !== {4{14'd4}}) $display("FAIL sw_addr: got %h want %h", cap_addr, {4{14'd4}}); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL sw_rsp: got v=%b d=%h e=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err); else pass_cnt++;
        issue(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL lw_valid: got %b want 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h want deadbeef", rsp_rdata); else pass_cnt++;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL lw_err: got %b want 0", rsp_err); else pass_cnt++;
    endtask

    task automatic test_byte();
        issue(1'b1, 16'h0013, 2'd0, 1'b0, 32'h00000080);
        issue(1'b0, 16'h0013, 2'd0, 1'b0, 32'h0);
        total_cnt++; if (rsp_rdata !== 32'hFFFFFF80) $display("FAIL lb: got %h want ffffff80", rsp_rdata); else pass_cnt++;
        issue(1'b0, 16'h0013, 2'd0, 1'b1, 32'h0);
        total_cnt++; if (rsp_rdata !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", rsp_rdata); else pass_cnt++;
        issue(1'b1, 16'h0012, 2'd0, 1'b0, 32'h00000080);
        issue(1'b1, 16'h0013, 2'd0, 1'b0, 32'h0000007F);
        issue(1'b0, 16'h0012, 2'd1, 1'b0, 32'h0);
        total_cnt++; if (rsp_rdata !== 32'h00007F80) $display("FAIL lh: got %h want 00007f80", rsp_rdata); else pass_cnt++;
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_EN
        issue(1'b1, 16'h0006, 2'd2, 1'b0, 32'h11223344);
        total_cnt++; if (cap_addr !== {14'd1, 14'd1, 14'd2, 14'd2})
            $display("FAIL mis_sw_addr: got %h want %h", cap_addr, {14'd1, 14'd1, 14'd2, 14'd2}); else pass_cnt++;
        total_cnt++; if (ram[2][1] !== 8'h44 || ram[3][1] !== 8'h33 || ram[0][2] !== 8'h22 || ram[1][2] !== 8'h11)
            $display("FAIL mis_sw_ram: got %h %h %h %h want 44 33 22 11", ram[2][1], ram[3][1], ram[0][2], ram[1][2]); else pass_cnt++;
        issue(1'b0, 16'h0006, 2'd2, 1'b0, 32'h0);
        total_cnt++; if (rsp_rdata !== 32'h11223344 || rsp_err !== 1'b0)
            $display("FAIL mis_lw: got %h err %b want 11223344 err 0", rsp_rdata, rsp_err); else pass_cnt++;
        issue(1'b1, 16'hFFFF, 2'd1, 1'b0, 32'h0000ABCD);
        total_cnt++; if (ram[3][16383] !== 8'hCD || ram[0][0] !== 8'hAB)
            $display("FAIL wrap_sh_ram: got %h %h want cd ab", ram[3][16383], ram[0][0]); else pass_cnt++;
        issue(1'b0, 16'hFFFF, 2'd1, 1'b1, 32'h0);
        total_cnt++; if (rsp_rdata !== 32'h0000ABCD || rsp_err !== 1'b0)
            $display("FAIL wrap_lhu: got %h err %b want 0000abcd err 0", rsp_rdata, rsp_err); else pass_cnt++;
`else
        issue(1'b0, 16'h0003, 2'd1, 1'b0, 32'h0);
        total_cnt++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            $display("FAIL mis_lh: got err %b rdata %h want err 1 rdata 0", rsp_err, rsp_rdata); else pass_cnt++;
        issue(1'b1, 16'h0002, 2'd2, 1'b0, 32'h12345678);
        total_cnt++; if (rsp_err !== 1'b1) $display("FAIL mis_sw_err: got %b want 1", rsp_err); else pass_cnt++;
        total_cnt++; if (cap_wren !== 4'b0000) $display("FAIL mis_sw_wren: got %b want 0000", cap_wren); else pass_cnt++;
        issue(1'b0, 16'h0011, 2'd2, 1'b0, 32'h0);
        total_cnt++; if (cap_addr !== {4{14'd4}}) $display("FAIL mis_lw_addr: got %h want %h", cap_addr, {4{14'd4}}); else pass_cnt++;
`endif
    endtask

    task automatic test_size3();
        issue(1'b1, 16'h0020, 2'd3, 1'b0, 32'hCAFEF00D);
        total_cnt++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            $display("FAIL size3_st: got err %b rdata %h want err 1 rdata 0", rsp_err, rsp_rdata); else pass_cnt++;
        total_cnt++; if (cap_wren !== 4'b0000) $display("FAIL size3_wren: got %b want 0000", cap_wren); else pass_cnt++;
        issue(1'b0, 16'h0010, 2'd3, 1'b0, 32'h0);
        total_cnt++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            $display("FAIL size3_ld: got err %b rdata %h want err 1 rdata 0", rsp_err, rsp_rdata); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [15:0] addrs [4];
        logic [1:0]  sizes [4];
        addrs = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        sizes = '{2'd2, 2'd0, 2'd1, 2'd0};
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
        held = exp_rdata;
        total_cnt++; if (cap_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== held)
            $display("FAIL bp_load: got rdy %b v %b d %h want 1 1 %h", cap_ready, rsp_valid, rsp_rdata, held); else pass_cnt++;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'h5555AAAA;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready #%0d: got %b want 0", c, req_ready); else pass_cnt++;
            total_cnt++; if (lane_wren !== 4'b0000) $display("FAIL bp_wren #%0d: got %b want 0000", c, lane_wren); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_err !== 1'b0)
                $display("FAIL bp_hold #%0d: got v %b d %h e %b want 1 %h 0", c, rsp_valid, rsp_rdata, rsp_err, held); else pass_cnt++;
        end
        rsp_ready = 1'b1;
        issue(1'b1, 16'h0010, 2'd2, 1'b0, 32'h5555AAAA);
        total_cnt++; if (cap_ready !== 1'b1 || cap_wren !== 4'b1111)
            $display("FAIL bp_release: got rdy %b wren %b want 1 1111", cap_ready, cap_wren); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL bp_store_rsp: got v %b d %h e %b want 1 0 0", rsp_valid, rsp_rdata, rsp_err); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, addrs[i], sizes[i], 1'b1, 32'h0);
            total_cnt++; if (cap_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata)
                $display("FAIL b2b #%0d: got rdy %b v %b d %h want 1 1 %h", i, cap_ready, rsp_valid, rsp_rdata, exp_rdata); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (rsp_rdata !== 32'h5555AAAA) $display("FAIL b2b_data: got %h want 5555aaaa", rsp_rdata); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 16'h0030, 2'd0, 1'b0, 32'h0000005A);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL midrst_rsp: got v %b d %h e %b want 0 0 0", rsp_valid, rsp_rdata, rsp_err); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", req_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 16'h0030, 2'd0, 1'b1, 32'h0);
        total_cnt++; if (rsp_rdata !== 32'h0000005A || rsp_rdata !== exp_rdata)
            $display("FAIL midrst_keep: got %h want 0000005a", rsp_rdata); else pass_cnt++;
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [31:0] wd;
        rsp_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            wd  = $urandom;
            if ($urandom_range(0, 3) == 0) a = 16'hFFC0 + 16'($urandom_range(0, 63));
            else                           a = 16'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(we, a, sz, uns, wd);
            total_cnt++; if (cap_ready !== 1'b1 || rsp_valid !== 1'b1)
                $display("FAIL rnd_hs #%0d: got rdy %b v %b want 1 1", t, cap_ready, rsp_valid); else pass_cnt++;
            total_cnt++; if (rsp_err !== exp_err) $display("FAIL rnd_err #%0d: got %b want %b", t, rsp_err, exp_err); else pass_cnt++;
            total_cnt++; if (rsp_rdata !== exp_rdata) $display("FAIL rnd_rdata #%0d: got %h want %h", t, rsp_rdata, exp_rdata); else pass_cnt++;
            total_cnt++; if (cap_wren !== exp_wren) $display("FAIL rnd_wren #%0d: got %b want %b", t, cap_wren, exp_wren); else pass_cnt++;
            total_cnt++; if (cap_addr !== exp_addr) $display("FAIL rnd_addr #%0d: got %h want %h", t, cap_addr, exp_addr); else pass_cnt++;
            if (we && !exp_err) begin
                total_cnt++; if (cap_wdata !== exp_wdata) $display("FAIL rnd_wdata #%0d: got %h want %h", t, cap_wdata, exp_wdata); else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; ram_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        ram_clear = 1'b0;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_word();
        test_byte();
        test_misalign();
        test_size3();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
